// File: rtl/mem_access_stage.sv
// mem_access_stage: memory-access stage between EX/MEM and write-back.
// It drives a variable-latency data-memory handshake and stalls the front of
// the pipeline while an access is outstanding. Byte loads are zero-extended,
// and the result is registered into MEM/WB.
// Optional build macro: MEM_ACK_TIMEOUT_EN. When it is defined, an access
// that waits too long for an ack is aborted and mem_err latches high.
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Mem_MemWE,
  input  logic        Mem_Mem2Reg,
  input  logic        Mem_RegWE,
  input  logic        Mem_LDURB_control,
  input  logic [3:0]  Mem_xfer_size,
  input  logic [4:0]  Mem_Rd,
  input  logic [63:0] Mem_data,
  input  logic [63:0] Mem_ReadData2,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  output logic [3:0]  dmem_size,
  input  logic        dmem_ack,
  input  logic [63:0] dmem_rdata,
  output logic        stall,
  output logic        Wb_RegWE,
  output logic [4:0]  Wb_Rd,
  output logic [63:0] Wb_data,
  output logic        mem_err
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;
  localparam logic [7:0] TO_LIM  = 8'(TIMEOUT_CYCLES);

  logic [0:0]  state, state_nxt;
  logic        memop;
  logic        abort;
  logic [63:0] load_result;

  assign memop = Mem_MemWE | Mem_Mem2Reg;

`ifdef MEM_ACK_TIMEOUT_EN
  logic [7:0] wait_cnt;
  logic [7:0] wait_cnt_inc;
  logic       err_q;

  // wait_cnt_inc is the 1-based index of the current WAIT cycle.
  // An ack in the same cycle wins over the abort.
  assign wait_cnt_inc = wait_cnt + 8'd1;
  assign abort = reset & (state == ST_WAIT) & ~dmem_ack & (wait_cnt_inc == TO_LIM);

  // Count WAIT cycles. The count clears whenever the access leaves WAIT.
  always_ff @(posedge clk) begin
    if (!reset)
      wait_cnt <= 8'd0;
    else if ((state == ST_WAIT) && !dmem_ack && !abort)
      wait_cnt <= wait_cnt_inc;
    else
      wait_cnt <= 8'd0;
  end

  // Sticky timeout flag. Only reset clears it.
  always_ff @(posedge clk) begin
    if (!reset)
      err_q <= 1'b0;
    else if (abort)
      err_q <= 1'b1;
  end

  assign mem_err = err_q;
`else
  logic unused_timeout;

  assign abort          = 1'b0;
  assign mem_err        = 1'b0;
  assign unused_timeout = |TO_LIM;
`endif

  // The request stays up for the whole access. Reset or an abort drops it
  // in the same cycle.
  assign dmem_req   = reset & (memop | (state == ST_WAIT)) & ~abort;
  assign dmem_we    = dmem_req & Mem_MemWE;
  assign dmem_addr  = Mem_data;
  assign dmem_wdata = Mem_ReadData2;
  assign dmem_size  = Mem_xfer_size;

  // Freeze upstream until the memory acks. An abort releases the freeze.
  assign stall = reset & memop & ~dmem_ack & ~abort;

  assign load_result = Mem_LDURB_control ? {56'b0, dmem_rdata[7:0]} : dmem_rdata;

  // Next-state logic. A zero-wait ack in IDLE never visits WAIT.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (memop && !dmem_ack) state_nxt = ST_WAIT;
      ST_WAIT: if (dmem_ack || abort)  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register. Reset forces IDLE.
  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // MEM/WB register.
  // A stall inserts a bubble and keeps Rd and data.
  // An abort also clears data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      Wb_RegWE <= 1'b0;
      Wb_Rd    <= 5'd0;
      Wb_data  <= 64'd0;
    end else if (abort) begin
      Wb_RegWE <= 1'b0;
      Wb_data  <= 64'd0;
    end else if (stall) begin
      Wb_RegWE <= 1'b0;
    end else begin
      Wb_RegWE <= Mem_RegWE;
      Wb_Rd    <= Mem_Rd;
      Wb_data  <= Mem_Mem2Reg ? load_result : Mem_data;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomised bench for mem_access_stage. A transaction-level model predicts
// the handshake and the MEM/WB contents, and a compare process checks the
// outputs every cycle. Directed cases pin the model with literal values.
module tb_mem_access_stage;

`ifdef MEM_ACK_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        Mem_MemWE = 0, Mem_Mem2Reg = 0, Mem_RegWE = 0, Mem_LDURB_control = 0;
  logic [3:0]  Mem_xfer_size = 0;
  logic [4:0]  Mem_Rd = 0;
  logic [63:0] Mem_data = 0, Mem_ReadData2 = 0;
  logic        dmem_req, dmem_we;
  logic [63:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_size;
  logic        dmem_ack = 0;
  logic [63:0] dmem_rdata = 0;
  logic        stall, Wb_RegWE, mem_err;
  logic [4:0]  Wb_Rd;
  logic [63:0] Wb_data;

  int checks = 0;
  int errors = 0;

  mem_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .Mem_MemWE(Mem_MemWE), .Mem_Mem2Reg(Mem_Mem2Reg), .Mem_RegWE(Mem_RegWE),
    .Mem_LDURB_control(Mem_LDURB_control), .Mem_xfer_size(Mem_xfer_size),
    .Mem_Rd(Mem_Rd), .Mem_data(Mem_data), .Mem_ReadData2(Mem_ReadData2),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_size(dmem_size), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .stall(stall), .Wb_RegWE(Wb_RegWE),
    .Wb_Rd(Wb_Rd), .Wb_data(Wb_data), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Model state: expected MEM/WB contents, the error flag, and the number of
  // cycles the current access has already been stalled.
  logic        e_we = 0;
  logic [4:0]  e_rd = 0;
  logic [63:0] e_data = 0;
  logic        e_err = 0;
  int          k = 0;

  always @(negedge clk) begin : cmp
    logic memop, to, x_req, x_stall;
    logic [63:0] res;
    memop   = Mem_MemWE | Mem_Mem2Reg;
    to      = TO_EN && reset && memop && !dmem_ack && (k >= TO);
    x_req   = reset && memop && !to;
    x_stall = x_req && !dmem_ack;
    chk("dmem_req", dmem_req, x_req);
    chk("stall", stall, x_stall);
    if (x_req) begin
      chk("dmem_we", dmem_we, Mem_MemWE);
      chk("dmem_addr", dmem_addr, Mem_data);
      chk("dmem_wdata", dmem_wdata, Mem_ReadData2);
      chk("dmem_size", dmem_size, Mem_xfer_size);
    end
    chk("Wb_RegWE", Wb_RegWE, e_we);
    chk("Wb_Rd", Wb_Rd, e_rd);
    chk("Wb_data", Wb_data, e_data);
    chk("mem_err", mem_err, e_err);
    res = Mem_LDURB_control ? (dmem_rdata & 64'hFF) : dmem_rdata;
    if (!reset) begin
      e_we = 0; e_rd = 0; e_data = 0; e_err = 0; k = 0;
    end else if (!memop || dmem_ack) begin
      e_we = Mem_RegWE; e_rd = Mem_Rd;
      e_data = Mem_Mem2Reg ? res : Mem_data;
      k = 0;
    end else if (to) begin
      e_we = 0; e_data = 0; e_err = 1; k = 0;
    end else begin
      e_we = 0; k++;
    end
  end

  // Present one operation at posedge+1. The memory acks on cycle 'lat'.
  // The task returns at posedge+1 after the operation completes.
  task automatic do_op(input bit we, m2r, rwe, lb, input logic [3:0] sz,
                       input logic [4:0] rd, input logic [63:0] a, wd,
                       input int lat, input logic [63:0] rv,
                       output int stalls, output int reqs);
    bit memop, done;
    stalls = 0; reqs = 0; done = 0;
    memop = we | m2r;
    Mem_MemWE = we; Mem_Mem2Reg = m2r; Mem_RegWE = rwe; Mem_LDURB_control = lb;
    Mem_xfer_size = sz; Mem_Rd = rd; Mem_data = a; Mem_ReadData2 = wd;
    for (int c = 0; c < 300 && !done; c++) begin
      dmem_ack   = memop ? (c == lat) : 1'($urandom_range(0, 1));
      dmem_rdata = (memop && c == lat) ? rv : {$urandom, $urandom};
      #3;
      if (stall) stalls++;
      if (dmem_req && dmem_we && dmem_wdata == wd && dmem_size == sz) reqs++;
      @(posedge clk); #1;
      done = !memop || (c == lat) || (TO_EN && c == TO);
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL op_timeout: no completion within 300 cycles");
    end
    dmem_ack = 0;
  endtask

  initial begin
    int s, r, ty, lat;
    logic [63:0] w;
    // Reset with a load presented: no request may escape during reset.
    Mem_Mem2Reg = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", dmem_req, 0);
    chk("rst_stall", stall, 0);
    chk("rst_wbwe", Wb_RegWE, 0);
    chk("rst_wbdata", Wb_data, 0);
    chk("rst_err", mem_err, 0);
    Mem_Mem2Reg = 0;
    reset = 1;

    // ALU op.
    do_op(0, 0, 1, 0, 4'd0, 5'd5, 64'h1234, 64'h0, 0, 64'h0, s, r);
    chk("alu_stall", s, 0);
    chk("alu_wbwe", Wb_RegWE, 1);
    chk("alu_wbrd", Wb_Rd, 5);
    chk("alu_wbdata", Wb_data, 64'h1234);
    // LDUR with a zero-wait ack.
    do_op(0, 1, 1, 0, 4'd8, 5'd3, 64'h40, 64'h0, 0, 64'hDEADBEEF_CAFEF00D, s, r);
    chk("ldur_stall", s, 0);
    chk("ldur_wbwe", Wb_RegWE, 1);
    chk("ldur_wbdata", Wb_data, 64'hDEADBEEF_CAFEF00D);
    // LDURB with 3 wait cycles.
    do_op(0, 1, 1, 1, 4'd1, 5'd7, 64'h41, 64'h0, 3, 64'hFFFF_FFFF_FFFF_FFA5, s, r);
    chk("ldurb_stall", s, 3);
    chk("ldurb_wbdata", Wb_data, 64'hA5);
    chk("ldurb_wbrd", Wb_Rd, 7);
    // STUR with 2 wait cycles.
    do_op(1, 0, 0, 0, 4'd8, 5'd0, 64'h80, 64'h55, 2, 64'h0, s, r);
    chk("stur_stall", s, 2);
    chk("stur_req_cycles", r, 3);
    chk("stur_wbwe", Wb_RegWE, 0);

    // Reset in the second WAIT cycle of a load.
    Mem_MemWE = 0; Mem_Mem2Reg = 1; Mem_RegWE = 1; Mem_LDURB_control = 0;
    Mem_Rd = 5'd9; Mem_data = 64'h100; dmem_ack = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 0;
    #2;
    chk("rstwait_req", dmem_req, 0);
    @(posedge clk); #1;
    chk("rstwait_wbwe", Wb_RegWE, 0);
    chk("rstwait_wbrd", Wb_Rd, 0);
    chk("rstwait_wbdata", Wb_data, 0);
    reset = 1;
    Mem_Mem2Reg = 0; Mem_RegWE = 0; dmem_ack = 1; dmem_rdata = 64'hBAD;
    @(posedge clk); #1;
    chk("late_ack_wbwe", Wb_RegWE, 0);
    dmem_ack = 0;

    if (TO_EN) begin
      do_op(0, 1, 1, 0, 4'd8, 5'd4, 64'h200, 64'h0, 1000, 64'h0, s, r);
      chk("to_stall", s, TO);
      chk("to_err", mem_err, 1);
      chk("to_wbwe", Wb_RegWE, 0);
      do_op(0, 0, 1, 0, 4'd0, 5'd6, 64'h77, 64'h0, 0, 64'h0, s, r);
      chk("to_alu_wbdata", Wb_data, 64'h77);
      chk("to_alu_wbwe", Wb_RegWE, 1);
    end

    // Random back-to-back traffic. The model and the compare process judge it.
    for (int i = 0; i < 300; i++) begin
      ty  = $urandom_range(0, 3);
      lat = TO_EN ? $urandom_range(0, 7) : $urandom_range(0, 5);
      w   = {$urandom, $urandom};
      do_op(ty == 3, ty == 1 || ty == 2, 1'($urandom_range(0, 1)) | (ty != 3),
            ty == 2, 4'($urandom), 5'($urandom), {$urandom, $urandom}, w,
            lat, {$urandom, $urandom}, s, r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
